window_stat_collector: RTL and testbench

WINDOW_STAT_COLLECTOR -- requirements
Module: window_stat_collector

---
 rtl/window_stat_collector.sv | 115 +++++++++++
 tb/tb_window_stat_collector.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_stat_collector.sv
// Window statistics collector: accumulates unsigned sums and a signed peak over
// WINDOW samples (or until flush), then holds the result until downstream takes it.
module window_stat_collector #(
   parameter int WINDOW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_sum,
   input  logic [7:0]  in_max,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_total,
   output logic [7:0]  out_peak,
   output logic [7:0]  out_count,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_EMIT
   } state_t;

   localparam logic [7:0] WIN = 8'(WINDOW);

   state_t      state_q, state_d;
   logic [15:0] total_q, total_d;
   logic [7:0]  peak_q, peak_d;
   logic [7:0]  count_q, count_d;
   logic        out_valid_q, out_valid_d;
   logic        in_ready_q, in_ready_d;
   logic        busy_q, busy_d;

   logic        accept;
   logic [7:0]  count_inc;
   logic        take_peak;

   always_comb begin
      accept    = in_valid & in_ready_q;
      count_inc = count_q + 8'd1;
      take_peak = $signed(in_max) > $signed(peak_q);

      state_d = state_q;
      total_d = total_q;
      peak_d  = peak_q;
      count_d = count_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               total_d = {8'd0, in_sum};
               peak_d  = in_max;
               count_d = 8'd1;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               total_d = total_q + {8'd0, in_sum};
               count_d = count_inc;
               if (take_peak) begin
                  peak_d = in_max;
               end
            end
            // a flush arriving with a sample closes the window after folding it in
            if ((accept && (count_inc == WIN)) || flush) begin
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      out_valid_d = (state_d == S_EMIT);
      in_ready_d  = (state_d != S_EMIT);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         total_q     <= 16'd0;
         peak_q      <= 8'h80;
         count_q     <= 8'd0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         peak_q      <= peak_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_total = total_q;
   assign out_peak  = peak_q;
   assign out_count = count_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_window_stat_collector.sv
// Bench for window_stat_collector: queue-based window model checked every cycle,
// plus directed scenarios with literal expectations on WINDOW=4 and WINDOW=255.
module tb_window_stat_collector;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_sum;
   logic [7:0]  in_max;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_total;
   logic [7:0]  out_peak;
   logic [7:0]  out_count;
   logic        busy;

   logic        b_rst_n;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [7:0]  b_in_sum;
   logic [7:0]  b_in_max;
   logic        b_out_valid;
   logic [15:0] b_out_total;
   logic [7:0]  b_out_peak;
   logic [7:0]  b_out_count;
   logic        b_busy;

   int n_total = 0;
   int n_bad   = 0;

   window_stat_collector #(.WINDOW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_max(in_max), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_total(out_total), .out_peak(out_peak),
      .out_count(out_count), .busy(busy)
   );

   window_stat_collector #(.WINDOW(255)) dut_big (
      .clk(clk), .rst_n(b_rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_sum(b_in_sum), .in_max(b_in_max), .flush(1'b0),
      .out_valid(b_out_valid), .out_ready(1'b1),
      .out_total(b_out_total), .out_peak(b_out_peak),
      .out_count(b_out_count), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: samples of the current (or last) window, plus open/emit flags.
   int qs[$];
   int qm[$];
   bit m_open = 0;
   bit m_emit = 0;
   bit m_init = 0;

   always @(posedge clk) begin
      bit was_open;
      if (!rst_n) begin
         m_init = 1;
         m_open = 0;
         m_emit = 0;
         qs.delete();
         qm.delete();
      end else if (m_init) begin
         if (m_emit) begin
            if (out_ready) m_emit = 0;
         end else begin
            was_open = m_open;
            if (in_valid) begin
               if (!m_open) begin
                  qs.delete();
                  qm.delete();
                  m_open = 1;
               end
               qs.push_back(int'(in_sum));
               qm.push_back(int'($signed(in_max)));
            end
            if (was_open && (qs.size() == 4 || flush)) begin
               m_emit = 1;
               m_open = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      int et;
      int ep;
      if (m_init) begin
         et = 0;
         ep = -128;
         foreach (qs[i]) et += qs[i];
         foreach (qm[i]) if (qm[i] > ep) ep = qm[i];
         chk("m_valid", int'(out_valid), int'(m_emit));
         chk("m_ready", int'(in_ready), int'(!m_emit));
         chk("m_busy", int'(busy), int'(m_emit || m_open));
         chk("m_total", int'(out_total), et);
         chk("m_peak", int'($signed(out_peak)), ep);
         chk("m_count", int'(out_count), qs.size());
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic cyc(input bit v, input int s, input int m, input bit f);
      in_valid = v;
      in_sum   = 8'(s);
      in_max   = 8'(m);
      flush    = f;
      tick();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, int'(out_valid), 0);
      chk({tag, "_total"}, int'(out_total), 0);
      chk({tag, "_peak"}, int'(out_peak), 128);
      chk({tag, "_count"}, int'(out_count), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_ready"}, int'(in_ready), 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_sum     = 8'd0;
      in_max     = 8'd0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      b_rst_n    = 1'b0;
      b_in_valid = 1'b0;
      b_in_sum   = 8'd0;
      b_in_max   = 8'd0;

      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk_reset("rst");
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);

      // full window
      cyc(1, 10, 5, 0);
      cyc(1, 20, -3, 0);
      cyc(1, 30, 127, 0);
      chk("full_pre_valid", int'(out_valid), 0);
      cyc(1, 40, -128, 0);
      chk("full_valid", int'(out_valid), 1);
      chk("full_total", int'(out_total), 100);
      chk("full_peak", int'($signed(out_peak)), 127);
      chk("full_count", int'(out_count), 4);
      chk("full_ready", int'(in_ready), 0);
      cyc(0, 0, 0, 0);
      chk("full_idle_valid", int'(out_valid), 0);
      chk("full_idle_busy", int'(busy), 0);
      chk("full_idle_ready", int'(in_ready), 1);

      // all-negative peaks
      cyc(1, 0, -128, 0);
      cyc(1, 0, -1, 0);
      cyc(1, 0, -50, 0);
      cyc(1, 0, -2, 0);
      chk("neg_valid", int'(out_valid), 1);
      chk("neg_peak", int'(out_peak), 255);
      chk("neg_total", int'(out_total), 0);
      cyc(0, 0, 0, 0);

      // flush in IDLE does nothing
      cyc(0, 0, 0, 1);
      chk("idle_flush_busy", int'(busy), 0);
      chk("idle_flush_valid", int'(out_valid), 0);

      // backpressure
      out_ready = 1'b0;
      cyc(1, 1, 0, 0);
      cyc(1, 2, 0, 0);
      cyc(1, 3, 0, 0);
      cyc(1, 4, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(1, 50 + k, k + 20, 1);
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_ready", int'(in_ready), 0);
         chk("bp_total", int'(out_total), 10);
         chk("bp_count", int'(out_count), 4);
      end
      out_ready = 1'b1;
      cyc(1, 99, 99, 0);
      chk("bp_rel_valid", int'(out_valid), 0);
      chk("bp_rel_ready", int'(in_ready), 1);
      chk("bp_rel_count", int'(out_count), 4);
      chk("bp_rel_total", int'(out_total), 10);
      cyc(0, 0, 0, 0);

      // flush with a coinciding accept
      cyc(1, 7, 3, 0);
      cyc(1, 8, 9, 0);
      cyc(1, 1, -4, 1);
      chk("fl_valid", int'(out_valid), 1);
      chk("fl_count", int'(out_count), 3);
      chk("fl_total", int'(out_total), 16);
      chk("fl_peak", int'($signed(out_peak)), 9);
      cyc(0, 0, 0, 0);

      // flush alone after a single sample
      cyc(1, 5, -7, 0);
      cyc(0, 0, 0, 1);
      chk("fl1_valid", int'(out_valid), 1);
      chk("fl1_count", int'(out_count), 1);
      chk("fl1_total", int'(out_total), 5);
      chk("fl1_peak", int'($signed(out_peak)), -7);
      cyc(0, 0, 0, 0);

      // reset mid-window, with accept and flush asserted alongside
      cyc(1, 3, 3, 0);
      cyc(1, 4, 4, 0);
      rst_n = 1'b0;
      cyc(1, 9, 9, 1);
      chk_reset("mid_rst");
      rst_n = 1'b1;
      cyc(1, 1, 1, 0);
      cyc(1, 2, 1, 0);
      cyc(1, 3, 1, 0);
      cyc(1, 4, 1, 0);
      chk("post_rst_valid", int'(out_valid), 1);
      chk("post_rst_count", int'(out_count), 4);
      chk("post_rst_total", int'(out_total), 10);
      cyc(0, 0, 0, 0);

      // WINDOW=255, every sample 255
      b_rst_n = 1'b1;
      tick();
      for (int i = 0; i < 255; i++) begin
         b_in_valid = 1'b1;
         b_in_sum   = 8'd255;
         b_in_max   = 8'(i);
         tick();
         if (i == 253) begin
            chk("big_pre_valid", int'(b_out_valid), 0);
            chk("big_pre_count", int'(b_out_count), 254);
            chk("big_pre_busy", int'(b_busy), 1);
         end
      end
      b_in_valid = 1'b0;
      chk("big_valid", int'(b_out_valid), 1);
      chk("big_total", int'(b_out_total), 65025);
      chk("big_count", int'(b_out_count), 255);
      chk("big_peak", int'($signed(b_out_peak)), 127);
      tick();
      chk("big_idle_valid", int'(b_out_valid), 0);
      chk("big_idle_ready", int'(b_in_ready), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
